// File: rtl/match_scanner_if.sv
// Bundles the scanner's control, stream and result signals.
// The master side drives the key and the data stream, and the slave side returns the results.
interface match_scanner_if #(
    parameter int N     = 32,
    parameter int CNT_W = 8
);
    logic             start;
    logic [N-1:0]     key;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             found;
    logic [CNT_W-1:0] first_idx;
    logic [CNT_W-1:0] match_count;

    modport master (
        output start, key, in_valid, in_data, in_last,
        input  in_ready, busy, done, found, first_idx, match_count
    );

    modport slave (
        input  start, key, in_valid, in_data, in_last,
        output in_ready, busy, done, found, first_idx, match_count
    );
endinterface

// File: rtl/match_scanner.sv
// match_scanner: streams words past a latched key and reduces the equality
// result into found / first-match index / saturating match count.
// Comparator: purely combinational N-bit equality cell.
module match_scanner #(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst,
    match_scanner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     key_reg;
    logic [CNT_W-1:0] idx;
    logic             found_q;
    logic [CNT_W-1:0] first_idx_q;
    logic [CNT_W-1:0] match_count_q;
    logic             eq;
    logic             ready_c;
    logic             busy_c;
    logic             done_c;
    logic             accept;

    Comparator #(.N(N)) u_cmp (
        .a   (bus.in_data),
        .b   (key_reg),
        .out (eq)
    );

    assign accept = bus.in_valid & ready_c;

    // State register; reset drops straight back to IDLE with no done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; handshake outputs depend only on state.
    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                ready_c = 1'b1;
                busy_c  = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Key latch and result reduction; first_idx is captured only on the first hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg       <= '0;
            idx           <= '0;
            found_q       <= 1'b0;
            first_idx_q   <= '0;
            match_count_q <= '0;
        end else if (state == IDLE && bus.start) begin
            key_reg       <= bus.key;
            idx           <= '0;
            found_q       <= 1'b0;
            first_idx_q   <= '0;
            match_count_q <= '0;
        end else if (accept) begin
            if (eq && match_count_q != {CNT_W{1'b1}}) begin
                match_count_q <= match_count_q + 1'b1;
            end
            if (eq && !found_q) begin
                found_q     <= 1'b1;
                first_idx_q <= idx;
            end
            idx <= idx + 1'b1;
        end
    end

    assign bus.in_ready    = ready_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.found       = found_q;
    assign bus.first_idx   = first_idx_q;
    assign bus.match_count = match_count_q;

endmodule

module Comparator #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out
);
    assign out = (a == b);
endmodule

// File: tb/tb_match_scanner.sv
// Bench for match_scanner: two instances (CNT_W=8 and CNT_W=2) see the same
// stream and are checked against a list-based reference model.
module tb_match_scanner;

    localparam int N = 32;

    logic clk;
    logic rst;

    match_scanner_if #(.N(N), .CNT_W(8)) bus ();
    match_scanner_if #(.N(N), .CNT_W(2)) bus_s ();

    match_scanner #(.N(N), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    match_scanner #(.N(N), .CNT_W(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    assign bus_s.start    = bus.start;
    assign bus_s.key      = bus.key;
    assign bus_s.in_valid = bus.in_valid;
    assign bus_s.in_data  = bus.in_data;
    assign bus_s.in_last  = bus.in_last;

    int checks = 0;
    int errors = 0;

    logic [31:0] words_q[$];
    int          gaps_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Moves to just after the next rising edge, where inputs change and outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference results straight from the stream: position of first hit taken
    // modulo the counter range, hit count clipped at the counter maximum.
    task automatic model(input logic [31:0] k, input int w,
                         output logic f, output int fi, output int mc);
        int lim;
        lim = (1 << w) - 1;
        f   = 1'b0;
        fi  = 0;
        mc  = 0;
        foreach (words_q[i]) begin
            if (words_q[i] == k) begin
                if (!f) begin
                    f  = 1'b1;
                    fi = i % (1 << w);
                end
                if (mc < lim) mc++;
            end
        end
    endtask

    task automatic checkResults(input string tag, input logic [31:0] k);
        logic f;
        int   fi;
        int   mc;
        model(k, 8, f, fi, mc);
        checkOutput({tag, "_found"}, 32'(bus.found), 32'(f));
        checkOutput({tag, "_first_idx"}, 32'(bus.first_idx), fi);
        checkOutput({tag, "_match_count"}, 32'(bus.match_count), mc);
        model(k, 2, f, fi, mc);
        checkOutput({tag, "_s_found"}, 32'(bus_s.found), 32'(f));
        checkOutput({tag, "_s_first_idx"}, 32'(bus_s.first_idx), fi);
        checkOutput({tag, "_s_match_count"}, 32'(bus_s.match_count), mc);
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_ready"}, 32'(bus.in_ready), 0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 0);
        checkOutput({tag, "_done"}, 32'(bus.done), 0);
        checkOutput({tag, "_found"}, 32'(bus.found), 0);
        checkOutput({tag, "_first_idx"}, 32'(bus.first_idx), 0);
        checkOutput({tag, "_match_count"}, 32'(bus.match_count), 0);
        checkOutput({tag, "_s_match_count"}, 32'(bus_s.match_count), 0);
    endtask

    // Runs one scan from IDLE over words_q with gaps_q idle cycles before each beat.
    task automatic applyStimulus(input logic [31:0] k);
        bus.start    = 1'b1;
        bus.key      = k;
        bus.in_valid = 1'b1;
        bus.in_data  = k;
        bus.in_last  = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.key      = $urandom;
        checkOutput("scan_busy", 32'(bus.busy), 1);
        checkOutput("scan_ready", 32'(bus.in_ready), 1);
        foreach (words_q[i]) begin
            for (int g = 0; g < gaps_q[i]; g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = k;
                bus.in_last  = 1'($urandom % 2);
                bus.start    = 1'($urandom % 2);
                step();
                checkOutput("gap_done", 32'(bus.done), 0);
                checkOutput("gap_busy", 32'(bus.busy), 1);
            end
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = words_q[i];
            bus.in_last  = (i == words_q.size() - 1);
            step();
            if (i != words_q.size() - 1) begin
                checkOutput("beat_done", 32'(bus.done), 0);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.start    = 1'b1;
        checkOutput("done_pulse", 32'(bus.done), 1);
        checkOutput("done_busy", 32'(bus.busy), 0);
        checkOutput("done_ready", 32'(bus.in_ready), 0);
        checkOutput("s_done_pulse", 32'(bus_s.done), 1);
        checkResults("done", k);
        step();
        bus.start = 1'b0;
        checkOutput("after_done", 32'(bus.done), 0);
        checkOutput("after_busy", 32'(bus.busy), 0);
        checkResults("hold", k);
        step();
        checkOutput("idle_busy", 32'(bus.busy), 0);
        checkResults("idle", k);
    endtask

    task automatic setStream(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3, input int len);
        logic [31:0] tmp[4];
        tmp = '{w0, w1, w2, w3};
        words_q.delete();
        gaps_q.delete();
        for (int i = 0; i < len; i++) begin
            words_q.push_back(tmp[i]);
            gaps_q.push_back(0);
        end
    endtask

    initial begin
        logic [31:0] k;
        int          len;

        // Reset with random inputs; outputs must clear asynchronously.
        rst          = 1'b1;
        bus.start    = 1'($urandom % 2);
        bus.key      = $urandom;
        bus.in_valid = 1'($urandom % 2);
        bus.in_data  = $urandom;
        bus.in_last  = 1'($urandom % 2);
        #3;
        checkZero("reset");
        step();
        step();
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
        end
        checkZero("post_reset");

        setStream(32'h1, 32'h2, 32'hDEADBEEF, 32'h4, 4);
        applyStimulus(32'hDEADBEEF);

        setStream(32'h0, 32'h5, 32'h0, 32'h0, 4);
        applyStimulus(32'h0);

        setStream(32'h1, 32'h2, 32'h0, 32'h0, 2);
        applyStimulus(32'h7);

        setStream(32'h9, 32'h33, 32'h4, 32'h0, 3);
        gaps_q[1] = 2;
        applyStimulus(32'h33);

        words_q.delete();
        gaps_q.delete();
        for (int i = 0; i < 6; i++) begin
            words_q.push_back(32'hA5A5);
            gaps_q.push_back(0);
        end
        applyStimulus(32'hA5A5);

        setStream(32'h8, 32'h0, 32'h0, 32'h0, 1);
        applyStimulus(32'h8);

        // Reset partway through a scan: clears immediately, no done pulse.
        bus.start    = 1'b1;
        bus.key      = 32'h55;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h55;
        step();
        step();
        checkOutput("pre_rst_count", 32'(bus.match_count), 2);
        #2;
        rst = 1'b1;
        #1;
        checkZero("mid_rst");
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("rst_no_done", 32'(bus.done), 0);
            checkOutput("rst_idle_busy", 32'(bus.busy), 0);
        end
        setStream(32'h55, 32'h1, 32'h55, 32'h2, 4);
        applyStimulus(32'h55);

        // Randomized scans across both counter widths.
        for (int s = 0; s < 20; s++) begin
            k   = $urandom;
            len = $urandom_range(1, 12);
            words_q.delete();
            gaps_q.delete();
            for (int i = 0; i < len; i++) begin
                words_q.push_back(($urandom % 2) ? k : $urandom);
                gaps_q.push_back(($urandom % 4 == 0) ? $urandom_range(1, 3) : 0);
            end
            applyStimulus(k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
